// File: rtl/cjb_nbit_arith_unit_seq_v_pkg.sv
// Shared definitions for the cjbRISC sequential arithmetic unit:
// function codes, FSM state encodings and CNVZ flag bit positions.
package cjb_nbit_arith_unit_seq_v_pkg;

  localparam int FUNC_W = 3;

  localparam logic [FUNC_W-1:0] FUNC_ADD  = 3'b000;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 3'b001;
  localparam logic [FUNC_W-1:0] FUNC_ADDK = 3'b010;
  localparam logic [FUNC_W-1:0] FUNC_SUBK = 3'b011;
  localparam logic [FUNC_W-1:0] FUNC_MUL  = 3'b100;
  localparam logic [FUNC_W-1:0] FUNC_MULH = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULT = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // MUL and MULH take the multi-cycle shift-add path; everything else is one pass of the adder.
  function automatic logic is_mul_func(input logic [FUNC_W-1:0] f);
    return (f == FUNC_MUL) || (f == FUNC_MULH);
  endfunction

endpackage

// File: rtl/cjb_nbit_arith_unit_seq_v_if.sv
// Request/result bundle between the control unit (master) and the arithmetic unit (slave).
interface cjb_nbit_arith_unit_seq_v_if
  import cjb_nbit_arith_unit_seq_v_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int K_WIDTH = 2
) ();

  logic               Start;
  logic [FUNC_W-1:0]  Func_Sel;
  logic [WIDTH-1:0]   Operand_X;
  logic [WIDTH-1:0]   Operand_Y;
  logic [K_WIDTH-1:0] Const_K;
  logic               Busy;
  logic               Done;
  logic [WIDTH-1:0]   Arith_Result;
  logic [3:0]         Arith_CNVZ;

  modport master (
    output Start, Func_Sel, Operand_X, Operand_Y, Const_K,
    input  Busy, Done, Arith_Result, Arith_CNVZ
  );

  modport slave (
    input  Start, Func_Sel, Operand_X, Operand_Y, Const_K,
    output Busy, Done, Arith_Result, Arith_CNVZ
  );

endinterface

// File: rtl/cjb_nbit_arith_unit_seq_v_addsub.sv
// Ripple-carry adder built from explicit full-adder cells; overflow is the
// exclusive-or of the carries into and out of the sign bit.
module cjb_nbit_addsub_struc_v #(
  parameter int WIDTH = 8
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout     = carry[WIDTH];
  assign overflow = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/cjb_nbit_arith_unit_seq_v.sv
// Sequential arithmetic unit: single-pass add/sub (+constant) and an unsigned
// shift-add multiplier sharing one adder instance.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for Start; operands and function latched on accept
//   MULT    | one shift-add iteration per cycle, WIDTH iterations total
//   FIN     | result and flags written, Done pulses on the following cycle
module cjb_nbit_arith_unit_seq_v
  import cjb_nbit_arith_unit_seq_v_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int K_WIDTH = 2
) (
  input  logic Clock,
  input  logic Reset,
  cjb_nbit_arith_unit_seq_v_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;
  logic   accept;

  logic [FUNC_W-1:0]  func_q;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [K_WIDTH-1:0] k_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       cnvz_q, cnvz_d;
  logic             done_q, done_d;

  logic             add_cin;
  logic [WIDTH-1:0] add_x, add_y, add_sum;
  logic             add_cout, add_ovf;
  logic [WIDTH-1:0] k_ext;
  logic [WIDTH-1:0] acc_hi, acc_lo;

  assign k_ext  = WIDTH'(k_q);
  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];

  // Adder operand selection: accumulate step in MULT, otherwise the latched add/sub operation.
  always_comb begin
    add_x   = x_q;
    add_y   = y_q;
    add_cin = 1'b0;
    if (state_q == ST_MULT) begin
      add_x = acc_hi;
      add_y = x_q;
    end else begin
      case (func_q)
        FUNC_SUB: begin
          add_y   = ~y_q;
          add_cin = 1'b1;
        end
        FUNC_ADDK: add_y = k_ext;
        FUNC_SUBK: begin
          add_y   = ~k_ext;
          add_cin = 1'b1;
        end
        default: add_y = y_q;
      endcase
    end
  end

  cjb_nbit_addsub_struc_v #(.WIDTH(WIDTH)) u_addsub (
    .cin      (add_cin),
    .x        (add_x),
    .y        (add_y),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a Start during the Done cycle is still treated as busy and dropped.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start && !done_q) begin
          accept  = 1'b1;
          state_d = is_mul_func(bus.Func_Sel) ? ST_MULT : ST_FIN;
        end
      end
      ST_MULT: if (cnt_q == CNT_LAST) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, iteration counter and shift-add accumulator; the multiplier shifts out of y_q.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      func_q <= FUNC_ADD;
      x_q    <= '0;
      y_q    <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (accept) begin
      func_q <= bus.Func_Sel;
      x_q    <= bus.Operand_X;
      y_q    <= bus.Operand_Y;
      k_q    <= bus.Const_K;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (state_q == ST_MULT) begin
      if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CNT_W'(1);
      if (y_q[0]) acc_q <= {add_cout, add_sum, acc_lo[WIDTH-1:1]};
      else        acc_q <= {1'b0, acc_q[2*WIDTH-1:1]};
      y_q <= y_q >> 1;
    end
  end

  // Result and flag selection in FIN; outputs hold their value otherwise.
  always_comb begin
    result_d = result_q;
    cnvz_d   = cnvz_q;
    done_d   = 1'b0;
    if (state_q == ST_FIN) begin
      done_d = 1'b1;
      case (func_q)
        FUNC_MUL: begin
          result_d         = acc_lo;
          cnvz_d[FLAG_C]   = |acc_hi;
          cnvz_d[FLAG_V]   = |acc_hi;
          cnvz_d[FLAG_N]   = acc_lo[WIDTH-1];
          cnvz_d[FLAG_Z]   = ~|acc_lo;
        end
        FUNC_MULH: begin
          result_d         = acc_hi;
          cnvz_d[FLAG_C]   = 1'b0;
          cnvz_d[FLAG_V]   = 1'b0;
          cnvz_d[FLAG_N]   = acc_hi[WIDTH-1];
          cnvz_d[FLAG_Z]   = ~|acc_hi;
        end
        default: begin
          result_d         = add_sum;
          cnvz_d[FLAG_C]   = add_cout;
          cnvz_d[FLAG_V]   = add_ovf;
          cnvz_d[FLAG_N]   = add_sum[WIDTH-1];
          cnvz_d[FLAG_Z]   = ~|add_sum;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      result_q <= '0;
      cnvz_q   <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      cnvz_q   <= cnvz_d;
      done_q   <= done_d;
    end
  end

  // Busy stays high through the Done cycle so it drops together with Done.
  assign bus.Busy         = (state_q != ST_IDLE) || done_q;
  assign bus.Done         = done_q;
  assign bus.Arith_Result = result_q;
  assign bus.Arith_CNVZ   = cnvz_q;

endmodule
